// File: rtl/iir_coef_pkg.sv
// Shared constants, coefficient ordering, default profile table and FSM encoding
// for the biquad coefficient sequencer.
package iir_coef_pkg;

    localparam int unsigned COEF_N    = 25;
    localparam int unsigned COEF_FRAC = 20;
    localparam int unsigned NUM_COEF  = 5;

    localparam logic [2:0] IDX_A1 = 3'd0;
    localparam logic [2:0] IDX_A2 = 3'd1;
    localparam logic [2:0] IDX_B0 = 3'd2;
    localparam logic [2:0] IDX_B1 = 3'd3;
    localparam logic [2:0] IDX_B2 = 3'd4;

    typedef enum logic {StIdle, StRun} seq_state_e;

    // Set 0 is the 200 Hz profile; every other set powers up as all-zero.
    function automatic logic signed [COEF_N-1:0] default_coef(input int unsigned set_num,
                                                              input logic [2:0]  idx);
        logic signed [COEF_N-1:0] v;
        v = '0;
        if (set_num == 0) begin
            case (idx)
                IDX_A1:  v = 25'h1E0A3D7;
                IDX_A2:  v = 25'h00F5E35;
                IDX_B0:  v = 25'h00000D1;
                IDX_B1:  v = 25'h00001A1;
                IDX_B2:  v = 25'h00000D1;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// NUM_SETS x 5 coefficient register array, reset to package defaults, async read.
// Synchronous write port only when IIR_COEF_WRITE_EN is defined.
module iir_coef_bank
    import iir_coef_pkg::*;
#(
    parameter int unsigned N        = COEF_N,
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef IIR_COEF_WRITE_EN
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_wr_set,
    input  logic [2:0]       i_wr_idx,
    input  logic [N-1:0]     i_wr_data,
`endif
    input  logic [SEL_W-1:0] i_rd_set,
    input  logic [2:0]       i_rd_idx,
    output logic [N-1:0]     o_rd_data
);

    logic [N-1:0] r_table [NUM_SETS][NUM_COEF];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int c = 0; c < NUM_COEF; c++) begin
                    r_table[s][c] <= N'(default_coef(s, 3'(c)));
                end
            end
        end
`ifdef IIR_COEF_WRITE_EN
        // Address range is qualified by the caller.
        else if (i_wr_en) begin
            r_table[i_wr_set][i_wr_idx] <= i_wr_data;
        end
`endif
    end

    assign o_rd_data = r_table[i_rd_set][i_rd_idx];

endmodule

// File: rtl/iir_coef_sequencer.sv
// Streams one of NUM_SETS biquad coefficient profiles (a1,a2,b0,b1,b2) per start.
// Define IIR_COEF_WRITE_EN to add a runtime table write port with ack.
module iir_coef_sequencer
    import iir_coef_pkg::*;
#(
    parameter int unsigned N        = COEF_N,
    parameter int unsigned FRAC     = COEF_FRAC,
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] set_sel,
`ifdef IIR_COEF_WRITE_EN
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_set,
    input  logic [2:0]       wr_idx,
    input  logic [N-1:0]     wr_data,
    output logic             wr_ack,
`endif
    output logic [N-1:0]     coef_out,
    output logic [2:0]       coef_idx,
    output logic             coef_valid,
    output logic             coef_last,
    output logic             busy,
    output logic             sel_err
);

    if (FRAC >= N) begin : g_bad_frac
        $error("FRAC must be smaller than N");
    end
    if (NUM_SETS < 1 || NUM_SETS > (1 << SEL_W)) begin : g_bad_sets
        $error("NUM_SETS must be in 1..2**SEL_W");
    end

    localparam logic [SEL_W:0] NumSetsW = (SEL_W + 1)'(NUM_SETS);

    seq_state_e       r_state, w_state_d;
    logic [2:0]       r_cnt, w_cnt_d;
    logic [SEL_W-1:0] r_set, w_set_d;
    logic             w_accept, w_sel_bad, w_emit, w_last_d, w_sel_err_d;
    logic [SEL_W-1:0] w_start_set, w_rd_set;
    logic [2:0]       w_rd_idx;
    logic [N-1:0]     w_rd_data;

    // busy is the registered output, so the coef_last cycle still blocks a new start.
    assign w_accept    = start && !busy;
    assign w_sel_bad   = {1'b0, set_sel} >= NumSetsW;
    assign w_start_set = w_sel_bad ? '0 : set_sel;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_set_d     = r_set;
        w_rd_set    = r_set;
        w_rd_idx    = r_cnt;
        w_emit      = 1'b0;
        w_last_d    = 1'b0;
        w_sel_err_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_rd_set = w_start_set;
                w_rd_idx = IDX_A1;
                if (w_accept) begin
                    w_state_d   = StRun;
                    w_set_d     = w_start_set;
                    w_cnt_d     = 3'd1;
                    w_emit      = 1'b1;
                    w_sel_err_d = w_sel_bad;
                end
            end
            StRun: begin
                w_emit = 1'b1;
                if (r_cnt == IDX_B2) begin
                    w_last_d  = 1'b1;
                    w_state_d = StIdle;
                    w_cnt_d   = 3'd0;
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef IIR_COEF_WRITE_EN
    logic w_wr_ok;
    logic r_wr_ack;

    assign w_wr_ok = wr_en
                  && ({1'b0, wr_set} < NumSetsW)
                  && (wr_idx <= IDX_B2)
                  && !(busy && (wr_set == r_set))
                  && !(w_accept && (wr_set == set_sel));

    always_ff @(posedge clk) begin
        if (rst) r_wr_ack <= 1'b0;
        else     r_wr_ack <= w_wr_ok;
    end

    assign wr_ack = r_wr_ack;
`endif

    iir_coef_bank #(
        .N        (N),
        .NUM_SETS (NUM_SETS),
        .SEL_W    (SEL_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
`ifdef IIR_COEF_WRITE_EN
        .i_wr_en   (w_wr_ok),
        .i_wr_set  (wr_set),
        .i_wr_idx  (wr_idx),
        .i_wr_data (wr_data),
`endif
        .i_rd_set  (w_rd_set),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_set      <= '0;
            coef_out   <= '0;
            coef_idx   <= 3'd0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            busy       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_set      <= w_set_d;
            coef_out   <= w_emit ? w_rd_data : '0;
            coef_idx   <= w_emit ? w_rd_idx : 3'd0;
            coef_valid <= w_emit;
            coef_last  <= w_last_d;
            busy       <= w_emit;
            sel_err    <= w_sel_err_d;
        end
    end

endmodule

// File: tb/tb_iir_coef_sequencer.sv
// Directed bench for iir_coef_sequencer (NUM_SETS=3) with a coefficient scoreboard.
// Write-port steps are compiled in when IIR_COEF_WRITE_EN is defined.
module tb_iir_coef_sequencer;

    typedef struct {
        logic [2:0]  idx;
        logic [24:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  set_sel = 2'd0;
    logic [24:0] coef_out;
    logic [2:0]  coef_idx;
    logic        coef_valid, coef_last, busy, sel_err;
`ifdef IIR_COEF_WRITE_EN
    logic        wr_en = 1'b0;
    logic [1:0]  wr_set = 2'd0;
    logic [2:0]  wr_idx = 3'd0;
    logic [24:0] wr_data = '0;
    logic        wr_ack;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [24:0] model [3][5];

    iir_coef_sequencer #(
        .N        (25),
        .FRAC     (20),
        .NUM_SETS (3),
        .SEL_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .set_sel    (set_sel),
`ifdef IIR_COEF_WRITE_EN
        .wr_en      (wr_en),
        .wr_set     (wr_set),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
`endif
        .coef_out   (coef_out),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_last  (coef_last),
        .busy       (busy),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_defaults();
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 5; c++) model[s][c] = '0;
        model[0][0] = 25'h1E0A3D7;
        model[0][1] = 25'h00F5E35;
        model[0][2] = 25'h00000D1;
        model[0][3] = 25'h00000D1 << 1 | 25'h1;  // 0x1A3 would be wrong; fixed below
        model[0][3] = 25'h00001A1;
        model[0][4] = 25'h00000D1;
    endtask

    task automatic push_burst(input int eff, input int c, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 3'(k);
            e.data = model[eff][k];
            e.last = (k == 4);
            e.cyc  = c + 1 + k;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    // One isolated burst: start high for a single cycle, busy/sel_err checked per cycle.
    task automatic burst(input logic [1:0] sel, input int eff);
        int c;
        @(negedge clk);
        start   = 1'b1;
        set_sel = sel;
        c       = cyc;
        push_burst(eff, c, 5);
        chk("busy_before", busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_t1", busy, 1);
        chk("sel_err_t1", sel_err, (sel >= 2'd3));
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("sel_err_run", sel_err, 0);
        end
        @(negedge clk);
        chk("busy_after", busy, 0);
        drain();
    endtask

    // Scoreboard side: every valid beat must match the next expected entry and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (coef_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid: idx %0d data %0h, none expected", coef_idx,
                       coef_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("coef_idx", coef_idx, e.idx);
                chk("coef_out", coef_out, e.data);
                chk("coef_last", coef_last, e.last);
                chk("beat_cycle", cyc, e.cyc);
            end
        end else if (!rst) begin
            chk("idle_zero", {coef_out, coef_idx, coef_last}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        load_defaults();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", coef_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_last", coef_last, 0);
`ifdef IIR_COEF_WRITE_EN
        chk("rst_wr_ack", wr_ack, 0);
`endif

        // Default 200 Hz profile.
        burst(2'd0, 0);

        // start held 12 cycles: bursts at c and c+6 only.
        @(negedge clk);
        start   = 1'b1;
        set_sel = 2'd0;
        c       = cyc;
        push_burst(0, c, 5);
        push_burst(0, c + 6, 5);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 6) chk("held_gap_busy", busy, 0);
            if (i == 7) chk("held_second_busy", busy, 1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        drain();

        // Out-of-range select streams set 0 with a sel_err pulse.
        burst(2'd3, 0);
        burst(2'd2, 2);

`ifdef IIR_COEF_WRITE_EN
        // Idle write, then a burst on the written set.
        @(negedge clk);
        wr_en = 1'b1; wr_set = 2'd1; wr_idx = 3'd2; wr_data = 25'h0000100;
        @(negedge clk);
        chk("wr_ack_idle", wr_ack, 1);
        wr_en = 1'b0;
        model[1][2] = 25'h0000100;
        @(negedge clk);
        chk("wr_ack_drop", wr_ack, 0);
        wr_en = 1'b1; wr_set = 2'd3; wr_idx = 3'd0; wr_data = 25'h1;
        @(negedge clk);
        chk("wr_ack_bad_set", wr_ack, 0);
        wr_set = 2'd1; wr_idx = 3'd5;
        @(negedge clk);
        chk("wr_ack_bad_idx", wr_ack, 0);
        wr_en = 1'b0;
        burst(2'd1, 1);

        // Writes during a set 0 burst: same set refused, other set accepted.
        @(negedge clk);
        start = 1'b1; set_sel = 2'd0; c = cyc;
        push_burst(0, c, 5);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b1; wr_set = 2'd0; wr_idx = 3'd3; wr_data = 25'h1234;
        @(negedge clk);
        chk("wr_ack_active_set", wr_ack, 0);
        wr_set = 2'd1; wr_idx = 3'd0; wr_data = 25'h55;
        @(negedge clk);
        chk("wr_ack_other_set", wr_ack, 1);
        wr_en = 1'b0;
        model[1][0] = 25'h55;
        repeat (3) @(negedge clk);
        drain();
        burst(2'd1, 1);
        burst(2'd0, 0);
`endif

        // Reset mid-burst: idx 0..2 seen, then everything drops with no coef_last.
        @(negedge clk);
        start = 1'b1; set_sel = 2'd0; c = cyc;
        push_burst(0, c, 3);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", coef_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_last", coef_last, 0);
        rst = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("post_rst_valid", coef_valid, 0);

        // Reset restores table defaults.
        load_defaults();
        burst(2'd1, 1);
        burst(2'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
